// File: rtl/dec_idex_pipe.sv
// Decode-to-execute stage: register bank, ID/EX register, load-use and forward select.
// Optional DEC_IDEX_PERF_EN adds saturating stall/flush event counters.
module dec_idex_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_valid,
    input  logic [AW-1:0]     i_addr_rs,
    input  logic [AW-1:0]     i_addr_rt,
    input  logic [AW-1:0]     i_addr_rd,
    input  logic              i_use_rs,
    input  logic              i_use_rt,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_pc4,
    input  logic              i_flush,
    input  logic              i_ex_hold,
    input  logic              i_E_regwrite,
    input  logic              i_E_memread,
    input  logic [AW-1:0]     i_E_rd,
    input  logic              i_M_regwrite,
    input  logic [AW-1:0]     i_M_rd,
    input  logic              i_W_regwrite,
    input  logic [AW-1:0]     i_W_rd,
    input  logic [DATA_W-1:0] i_W_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_rs,
    output logic [DATA_W-1:0] o_data_rt,
    output logic [DATA_W-1:0] o_data_rs_comb,
    output logic [AW-1:0]     o_addr_rt,
    output logic [AW-1:0]     o_addr_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_imm,
    output logic [DATA_W-1:0] o_pc4,
    output logic [1:0]        o_fa,
`ifdef DEC_IDEX_PERF_EN
    output logic [1:0]        o_fb,
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_flush_cnt
`else
    output logic [1:0]        o_fb
`endif
);

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              wr_en;
    logic              lu;
    logic [1:0]        fa_d;
    logic [1:0]        fb_d;

    assign wr_en = i_W_regwrite && (i_W_rd != '0);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en && (32'(i_W_rd) < NREG)) begin
            rf[i_W_rd] <= i_W_data;
        end
    end

    // Write-through so decode sees the value retiring this cycle.
    always_comb begin
        rs_val = '0;
        if (i_addr_rs != '0) begin
            if (wr_en && (i_W_rd == i_addr_rs)) rs_val = i_W_data;
            else if (32'(i_addr_rs) < NREG) rs_val = rf[i_addr_rs];
        end
    end

    always_comb begin
        rt_val = '0;
        if (i_addr_rt != '0) begin
            if (wr_en && (i_W_rd == i_addr_rt)) rt_val = i_W_data;
            else if (32'(i_addr_rt) < NREG) rt_val = rf[i_addr_rt];
        end
    end

    assign o_data_rs_comb = rs_val;

    assign lu = i_valid && i_E_memread && (i_E_rd != '0) &&
                ((i_use_rs && (i_E_rd == i_addr_rs)) ||
                 (i_use_rt && (i_E_rd == i_addr_rt)));

    assign o_stall = (lu || i_ex_hold) && !i_flush;

    // E match wins: that result is one stage younger than M's.
    always_comb begin
        fa_d = 2'b00;
        fb_d = 2'b00;
        if (i_use_rs) begin
            if (i_E_regwrite && (i_E_rd != '0) && (i_E_rd == i_addr_rs))
                fa_d = 2'b01;
            else if (i_M_regwrite && (i_M_rd != '0) && (i_M_rd == i_addr_rs))
                fa_d = 2'b10;
        end
        if (i_use_rt) begin
            if (i_E_regwrite && (i_E_rd != '0) && (i_E_rd == i_addr_rt))
                fb_d = 2'b01;
            else if (i_M_regwrite && (i_M_rd != '0) && (i_M_rd == i_addr_rt))
                fb_d = 2'b10;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_valid   <= 1'b0;
            o_data_rs <= '0;
            o_data_rt <= '0;
            o_addr_rt <= '0;
            o_addr_rd <= '0;
            o_ctrl    <= '0;
            o_imm     <= '0;
            o_pc4     <= '0;
            o_fa      <= 2'b00;
            o_fb      <= 2'b00;
        end else if (i_flush || (!i_ex_hold && lu)) begin
            o_valid <= 1'b0;
            o_ctrl  <= '0;
            o_fa    <= 2'b00;
            o_fb    <= 2'b00;
        end else if (!i_ex_hold) begin
            o_valid   <= i_valid;
            o_data_rs <= rs_val;
            o_data_rt <= rt_val;
            o_addr_rt <= i_addr_rt;
            o_addr_rd <= i_addr_rd;
            o_ctrl    <= i_valid ? i_ctrl : '0;
            o_imm     <= i_imm;
            o_pc4     <= i_pc4;
            o_fa      <= fa_d;
            o_fb      <= fb_d;
        end
    end

`ifdef DEC_IDEX_PERF_EN
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_stall && (o_stall_cnt != 16'hFFFF))
                o_stall_cnt <= o_stall_cnt + 16'd1;
            if (i_flush && (o_flush_cnt != 16'hFFFF))
                o_flush_cnt <= o_flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dec_idex_pipe.sv
// Bench for dec_idex_pipe: expected ID/EX contents queued on drive, checked after the edge.
// Counter checks run when DEC_IDEX_PERF_EN is defined.
module tb_dec_idex_pipe;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_valid;
    logic [4:0]  i_addr_rs, i_addr_rt, i_addr_rd;
    logic        i_use_rs, i_use_rt;
    logic [15:0] i_ctrl;
    logic [31:0] i_imm, i_pc4;
    logic        i_flush, i_ex_hold;
    logic        i_E_regwrite, i_E_memread;
    logic [4:0]  i_E_rd;
    logic        i_M_regwrite;
    logic [4:0]  i_M_rd;
    logic        i_W_regwrite;
    logic [4:0]  i_W_rd;
    logic [31:0] i_W_data;
    logic        o_stall, o_valid;
    logic [31:0] o_data_rs, o_data_rt, o_data_rs_comb;
    logic [4:0]  o_addr_rt, o_addr_rd;
    logic [15:0] o_ctrl;
    logic [31:0] o_imm, o_pc4;
    logic [1:0]  o_fa, o_fb;
`ifdef DEC_IDEX_PERF_EN
    logic [15:0] o_stall_cnt, o_flush_cnt;
`endif

    dec_idex_pipe dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_valid(i_valid),
        .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt), .i_addr_rd(i_addr_rd),
        .i_use_rs(i_use_rs), .i_use_rt(i_use_rt), .i_ctrl(i_ctrl),
        .i_imm(i_imm), .i_pc4(i_pc4), .i_flush(i_flush), .i_ex_hold(i_ex_hold),
        .i_E_regwrite(i_E_regwrite), .i_E_memread(i_E_memread), .i_E_rd(i_E_rd),
        .i_M_regwrite(i_M_regwrite), .i_M_rd(i_M_rd),
        .i_W_regwrite(i_W_regwrite), .i_W_rd(i_W_rd), .i_W_data(i_W_data),
        .o_stall(o_stall), .o_valid(o_valid),
        .o_data_rs(o_data_rs), .o_data_rt(o_data_rt),
        .o_data_rs_comb(o_data_rs_comb),
        .o_addr_rt(o_addr_rt), .o_addr_rd(o_addr_rd), .o_ctrl(o_ctrl),
        .o_imm(o_imm), .o_pc4(o_pc4), .o_fa(o_fa),
`ifdef DEC_IDEX_PERF_EN
        .o_fb(o_fb),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`else
        .o_fb(o_fb)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v;
        logic [15:0] ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        cd;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
    } exp_t;

    exp_t sbq[$];
    exp_t held;
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_valid = 0; i_addr_rs = 0; i_addr_rt = 0; i_addr_rd = 0;
        i_use_rs = 0; i_use_rt = 0; i_ctrl = 0; i_imm = 0; i_pc4 = 0;
        i_flush = 0; i_ex_hold = 0; i_E_regwrite = 0; i_E_memread = 0;
        i_E_rd = 0; i_M_regwrite = 0; i_M_rd = 0;
        i_W_regwrite = 0; i_W_rd = 0; i_W_data = 0;
    endtask

    function automatic exp_t mk(input logic v, input logic [15:0] c,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic cd, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [31:0] imm);
        exp_t e;
        e.v = v; e.ctrl = c; e.fa = fa; e.fb = fb;
        e.cd = cd; e.rs = rs; e.rt = rt; e.imm = imm;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(0, 16'h0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction

    task automatic cyc();
        exp_t e;
        @(posedge i_clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("valid", o_valid, e.v);
            chk("ctrl", o_ctrl, e.ctrl);
            chk("fa", o_fa, e.fa);
            chk("fb", o_fb, e.fb);
            if (e.cd) begin
                chk("data_rs", o_data_rs, e.rs);
                chk("data_rt", o_data_rt, e.rt);
                chk("imm", o_imm, e.imm);
            end
        end
    endtask

    initial begin
        idle();
        i_nrst = 0;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_data_rs", o_data_rs, 0);
        chk("rst_ctrl", o_ctrl, 0);
        chk("rst_fa", o_fa, 0);
        i_nrst = 1;
        @(posedge i_clk); #1;

        // r5 <= DEADBEEF, then read it back
        i_W_regwrite = 1; i_W_rd = 5; i_W_data = 32'hDEADBEEF;
        sbq.push_back(bubble());
        cyc();
        idle();
        i_valid = 1; i_addr_rs = 5; i_use_rs = 1; i_ctrl = 16'hA5A5;
        i_imm = 32'h11;
        sbq.push_back(mk(1, 16'hA5A5, 0, 0, 1, 32'hDEADBEEF, 0, 32'h11));
        cyc();

        // same-cycle write-through of r7
        idle();
        i_valid = 1; i_addr_rs = 7; i_use_rs = 1; i_ctrl = 16'h0007;
        i_W_regwrite = 1; i_W_rd = 7; i_W_data = 32'h1234;
        #1 chk("wt_comb", o_data_rs_comb, 32'h1234);
        sbq.push_back(mk(1, 16'h0007, 0, 0, 1, 32'h1234, 0, 0));
        cyc();

        // write to r0 ignored; E rd=0 never forwards
        idle();
        i_valid = 1; i_use_rs = 1; i_ctrl = 16'h0100;
        i_W_regwrite = 1; i_W_rd = 0; i_W_data = 32'hFFFFFFFF;
        i_E_regwrite = 1; i_E_rd = 0;
        #1 chk("r0_wt_comb", o_data_rs_comb, 0);
        sbq.push_back(mk(1, 16'h0100, 2'b00, 0, 1, 0, 0, 0));
        cyc();
        idle();
        i_valid = 1; i_use_rs = 1; i_ctrl = 16'h0101;
        #1 chk("r0_comb", o_data_rs_comb, 0);
        sbq.push_back(mk(1, 16'h0101, 0, 0, 1, 0, 0, 0));
        cyc();

        // load-use: one bubble, then forward from M
        idle();
        i_valid = 1; i_addr_rs = 3; i_use_rs = 1; i_ctrl = 16'h0033;
        i_E_memread = 1; i_E_regwrite = 1; i_E_rd = 3;
        #1 chk("lu_stall", o_stall, 1);
        sbq.push_back(bubble());
        cyc();
        i_E_memread = 0; i_E_regwrite = 0; i_E_rd = 0;
        i_M_regwrite = 1; i_M_rd = 3;
        #1 chk("lu_stall_off", o_stall, 0);
        sbq.push_back(mk(1, 16'h0033, 2'b10, 0, 1, 0, 0, 0));
        cyc();

        // forward priority on rt
        idle();
        i_valid = 1; i_addr_rt = 4; i_use_rt = 1; i_ctrl = 16'h0044;
        i_E_regwrite = 1; i_E_rd = 4; i_M_regwrite = 1; i_M_rd = 4;
        sbq.push_back(mk(1, 16'h0044, 0, 2'b01, 1, 0, 0, 0));
        cyc();
        i_E_regwrite = 0;
        sbq.push_back(mk(1, 16'h0044, 0, 2'b10, 1, 0, 0, 0));
        cyc();
        i_E_regwrite = 1; i_use_rt = 0;
        sbq.push_back(mk(1, 16'h0044, 0, 2'b00, 1, 0, 0, 0));
        cyc();

        // flush beats hold
        idle();
        i_valid = 1; i_ctrl = 16'h0F0F; i_flush = 1; i_ex_hold = 1;
        #1 chk("flush_stall", o_stall, 0);
        sbq.push_back(bubble());
        cyc();

        // capture, then hold for 3 cycles with changing inputs
        idle();
        i_valid = 1; i_addr_rs = 5; i_addr_rt = 7; i_use_rs = 1;
        i_use_rt = 1; i_ctrl = 16'h0BEE; i_imm = 32'h10; i_pc4 = 32'h104;
        held = mk(1, 16'h0BEE, 0, 0, 1, 32'hDEADBEEF, 32'h1234, 32'h10);
        sbq.push_back(held);
        cyc();
        for (int k = 0; k < 3; k++) begin
            i_ex_hold = 1; i_ctrl = 16'hFFFF; i_addr_rs = 7; i_imm = 32'(k);
            #1 chk("hold_stall", o_stall, 1);
            sbq.push_back(held);
            cyc();
        end

        // hold with lu: hold wins, lu bubble after release
        i_addr_rs = 5; i_ctrl = 16'h0055; i_imm = 32'h55;
        i_E_memread = 1; i_E_regwrite = 1; i_E_rd = 5;
        #1 chk("hold_lu_stall", o_stall, 1);
        sbq.push_back(held);
        cyc();
        i_ex_hold = 0;
        #1 chk("lu_after_hold", o_stall, 1);
        sbq.push_back(bubble());
        cyc();
        i_E_memread = 0; i_E_regwrite = 0; i_E_rd = 0;
        i_M_regwrite = 1; i_M_rd = 5;
        sbq.push_back(mk(1, 16'h0055, 2'b10, 0, 1, 32'hDEADBEEF, 32'h1234, 32'h55));
        cyc();

        // invalid slot loads ctrl as zero
        idle();
        i_ctrl = 16'h7777;
        sbq.push_back(mk(0, 16'h0, 0, 0, 0, 0, 0, 0));
        cyc();

        chk("sb_empty", 64'(sbq.size()), 0);

        // async reset mid-operation
        idle();
        i_valid = 1; i_addr_rs = 5; i_use_rs = 1; i_ctrl = 16'h00AA;
        @(posedge i_clk);
        #3;
        chk("pre_rst_valid", o_valid, 1);
        i_nrst = 0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_ctrl", o_ctrl, 0);
        chk("arst_data_rs", o_data_rs, 0);
        i_nrst = 1;
        #1 chk("arst_rf", o_data_rs_comb, 0);

`ifdef DEC_IDEX_PERF_EN
        idle();
        @(posedge i_clk); #1;
        i_ex_hold = 1;
        repeat (70000) @(posedge i_clk);
        #1;
        chk("stall_sat", o_stall_cnt, 16'hFFFF);
        i_ex_hold = 0;
        i_nrst = 0;
        #1;
        chk("cnt_rst_stall", o_stall_cnt, 0);
        chk("cnt_rst_flush", o_flush_cnt, 0);
        i_nrst = 1;
        @(posedge i_clk); #1;
        i_flush = 1;
        repeat (2) @(posedge i_clk);
        #1;
        i_flush = 0;
        chk("flush_cnt", o_flush_cnt, 2);
        chk("stall_cnt_flush", o_stall_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_idex_pipe.md
Name: dec_idex_pipe

Overview:
- Parametrised decode-to-execute stage: register bank, ID/EX pipeline register, load-use hazard detection, and forwarding-select generation.
- Sits between the fetch/IF-ID register and the execute stage.
- Generalises the fixed 32x32 decode stage:
  - configurable data width, register count and control-bundle width;
  - valid bit per stage;
  - stall/flush/hold handshake;
  - write-through bypass in the register bank.

Parameters:
DATA_W, 32, datapath and register width
NREG, 32, number of architectural registers; register 0 reads as zero
AW, $clog2(NREG), register address width (derived, not overridden)
CTRL_W, 16, width of opaque control bundle carried to E/M/W

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset
i_valid  in  1  IF/ID holds a valid instruction
i_addr_rs  in  AW  source A register
i_addr_rt  in  AW  source B register
i_addr_rd  in  AW  destination register
i_use_rs  in  1  instruction reads rs
i_use_rt  in  1  instruction reads rt
i_ctrl  in  CTRL_W  decoded control bundle
i_imm  in  DATA_W  extended immediate
i_pc4  in  DATA_W  PC+4 of instruction
i_flush  in  1  branch/jump resolved taken; kill instruction in decode
i_ex_hold  in  1  execute stage busy; freeze ID/EX
i_E_regwrite  in  1  instruction in E writes a register
i_E_memread  in  1  instruction in E is a load
i_E_rd  in  AW  E-stage destination
i_M_regwrite  in  1  instruction in M writes a register
i_M_rd  in  AW  M-stage destination
i_W_regwrite  in  1  writeback enable
i_W_rd  in  AW  writeback address
i_W_data  in  DATA_W  writeback data
o_stall  out  1  hold PC and IF/ID this cycle
o_valid  out  1  ID/EX holds a valid instruction
o_data_rs  out  DATA_W  registered rs value
o_data_rt  out  DATA_W  registered rt value
o_data_rs_comb  out  DATA_W  unregistered rs value (jump-register target)
o_addr_rt  out  AW  registered rt address
o_addr_rd  out  AW  registered rd address
o_ctrl  out  CTRL_W  registered control bundle
o_imm  out  DATA_W  registered immediate
o_pc4  out  DATA_W  registered PC+4
o_fa  out  2  registered forward select A
o_fb  out  2  registered forward select B

Behaviour:
- Reset: i_nrst, asynchronous, active-low; clock i_clk. All outputs and register bank contents are 0 on reset; o_stall is 0 out of reset.
- Register bank:
  - Two combinational read ports; write on posedge when i_W_regwrite=1 and i_W_rd!=0.
  - Writes to reg 0 are ignored; reg 0 always reads 0.
  - Write-through: if i_W_regwrite and i_W_rd==read address!=0, the read returns i_W_data in the same cycle.
- Load-use hazard:
  - lu = i_valid & i_E_memread & i_E_rd!=0 & ((i_use_rs & i_E_rd==i_addr_rs) | (i_use_rt & i_E_rd==i_addr_rt)).
- Stall output:
  - o_stall = (lu | i_ex_hold) & ~i_flush; combinational.
- Forward select, per operand X, computed in decode and registered:
  - 2'b01 if i_E_regwrite & i_E_rd!=0 & i_E_rd==X (E result will be in M next cycle);
  - else 2'b10 if i_M_regwrite & i_M_rd!=0 & i_M_rd==X;
  - else 2'b00.
  - E match has priority over M match.
  - Operands with i_use_*=0 produce 2'b00.
- ID/EX update priority on each posedge:
  1. i_flush: load bubble. o_valid=0, o_ctrl=0, o_fa=o_fb=0; data fields don't-care, kept at previous value. Flush overrides hold and lu.
  2. i_ex_hold: all ID/EX fields keep their value.
  3. lu: load bubble (as flush). IF/ID is held upstream via o_stall.
  4. Otherwise: capture all inputs; o_valid=i_valid. When i_valid=0, o_ctrl is loaded as 0.
- Latency: one cycle from decode inputs to registered outputs. A load-use costs exactly one bubble. After that bubble the load is in M, so the consumer gets fb/fa=2'b10.
- Simultaneous lu and i_ex_hold: hold wins. Stall persists, and lu is re-evaluated once hold drops.
- Asynchronous reset mid-operation clears o_valid immediately. No partial state survives.

Optional Feature:
- Macro: DEC_IDEX_PERF_EN.
- Defined: adds outputs o_stall_cnt[15:0] and o_flush_cnt[15:0].
  - o_stall_cnt increments on each cycle where o_stall=1.
  - o_flush_cnt increments on each cycle where i_flush=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then write: W writes r5=32'hDEADBEEF; next cycle read rs=5 gives o_data_rs=32'hDEADBEEF one clock later. Same-cycle write/read of r7=32'h1234 gives o_data_rs_comb=32'h1234.
- Write to r0 with 32'hFFFFFFFF: subsequent reads return 0; fa=00 even when E rd=0 and regwrite=1.
- Load-use: E memread=1, E_rd=3; decode rs=3, use_rs=1.
  - Expect o_stall=1 for one cycle and a bubble (o_valid=0, o_ctrl=0).
  - Next cycle (E_memread=0, M_rd=3, M_regwrite=1) the consumer is captured with o_fa=2'b10.
- Forward priority: E_rd=M_rd=4, both regwrite=1, decode rt=4 -> o_fb=2'b01. With E_regwrite=0 -> o_fb=2'b10.
- Flush vs hold: i_flush=1 and i_ex_hold=1 together -> o_stall=0, o_valid=0 next cycle. i_ex_hold alone for 3 cycles -> outputs stable and o_stall=1 throughout.
- Perf (DEC_IDEX_PERF_EN): drive 70000 stall cycles -> o_stall_cnt=16'hFFFF. A reset pulse mid-count -> both counters are 0.
